// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run sequencer / memory arbiter.
package run_ctrl_pkg;

    // Top-level sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        HOST
    } run_state_t;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int CW_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter
    import run_ctrl_pkg::*;
#(
    parameter int W = CW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer and data-memory arbiter between the host port and the core.
// Optional feature macro: RUN_WATCHDOG_EN (ends a run after MAX_CYC RUN cycles).
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int D          = 12,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int START_ADDR = 0,
    parameter int HALT_ADDR  = 128,
    parameter int CW         = CW_DEF,
    parameter int MAX_CYC    = 4000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [D-1:0]  prog_ctr_out,
    output logic          pc_load,
    output logic [D-1:0]  pc_load_val,
    output logic          core_en,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] run_cycles
);

`ifdef RUN_WATCHDOG_EN
    localparam bit WdogEn = 1'b1;
`else
    localparam bit WdogEn = 1'b0;
`endif

    run_state_t    state_q, state_d;
    logic          ret_done_q, ret_done_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          host_gnt_q, host_gnt_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic          host_we_q, host_we_d;
    logic [AW-1:0] host_addr_q, host_addr_d;
    logic [DW-1:0] host_wdata_q, host_wdata_d;
    logic          cnt_clr, cnt_inc;
    logic          at_halt;

    assign at_halt     = (prog_ctr_out == D'(HALT_ADDR));
    assign pc_load_val = D'(START_ADDR);

    sat_counter #(.W(CW)) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (run_cycles)
    );

    // Next-state, status flags, host capture and memory-port mux.
    always_comb begin
        state_d      = state_q;
        ret_done_d   = ret_done_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        host_gnt_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        host_we_d    = host_we_q;
        host_addr_d  = host_addr_q;
        host_wdata_d = host_wdata_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        pc_load      = 1'b0;
        core_en      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = core_addr;
        mem_wdata    = core_wdata;

        case (state_q)
            IDLE, DONE: begin
                // Start beats a host request; a request seen during the grant cycle is not a new one.
                if (start) begin
                    state_d   = LOAD;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_clr   = 1'b1;
                end else if (host_req && !host_gnt_q) begin
                    state_d      = HOST;
                    ret_done_d   = (state_q == DONE);
                    host_we_d    = host_we;
                    host_addr_d  = host_addr;
                    host_wdata_d = host_wdata;
                end
            end
            LOAD: begin
                pc_load = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                // The halt-address instruction is never executed nor counted.
                core_en = !at_halt;
                mem_we  = core_we && !at_halt;
                cnt_inc = !at_halt;
                if (at_halt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (WdogEn && (run_cycles == CW'(MAX_CYC - 1))) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            HOST: begin
                mem_we       = host_we_q;
                mem_addr     = host_addr_q;
                mem_wdata    = host_wdata_q;
                host_rdata_d = mem_rdata;
                host_gnt_d   = 1'b1;
                state_d      = ret_done_q ? DONE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and control registers; reset abandons any run or host access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ret_done_q   <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            host_gnt_q   <= 1'b0;
            host_rdata_q <= '0;
            host_we_q    <= 1'b0;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            ret_done_q   <= ret_done_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            host_gnt_q   <= host_gnt_d;
            host_rdata_q <= host_rdata_d;
            host_we_q    <= host_we_d;
            host_addr_q  <= host_addr_d;
            host_wdata_q <= host_wdata_d;
        end
    end

    assign done       = done_q;
    assign timeout    = timeout_q;
    assign host_gnt   = host_gnt_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: core PC model, data memory, and a
// transaction-level reference model checked every cycle.
module tb_run_ctrl;

    localparam int D         = 12;
    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int CW        = 16;
    localparam int HALT_ADDR = 128;
    localparam int MAX_CYC   = 20;
`ifdef RUN_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [D-1:0]  prog_ctr_out;
    logic          pc_load;
    logic [D-1:0]  pc_load_val;
    logic          core_en;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          done;
    logic          timeout;
    logic [CW-1:0] run_cycles;

    int checks = 0;
    int errors = 0;

    run_ctrl #(
        .D(D), .AW(AW), .DW(DW), .START_ADDR(0), .HALT_ADDR(HALT_ADDR),
        .CW(CW), .MAX_CYC(MAX_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_ctr_out(prog_ctr_out),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .core_en(core_en),
        .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .done(done), .timeout(timeout),
        .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core PC: load, step, optionally branch back to 0 at pc_wrap.
    logic          wrap_en = 1'b0;
    logic [D-1:0]  pc_wrap = '0;
    logic [D-1:0]  pc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             pc <= '0;
        else if (pc_load)       pc <= pc_load_val;
        else if (core_en)       pc <= (wrap_en && pc == pc_wrap) ? '0 : pc + 1'b1;
    end
    assign prog_ctr_out = pc;
    assign core_we      = pc[0];
    assign core_addr    = pc[7:0] ^ 8'h40;
    assign core_wdata   = pc[7:0] + 8'd3;

    // Data memory with combinational read.
    logic [DW-1:0] env_mem [256];
    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) if (mem_we) env_mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run_age 0 = no run, 1 = load cycle, 2 = running;
    // host_age 0 = none, 1 = access cycle, 2 = grant cycle.
    int            m_run_age, m_host_age;
    logic          m_done, m_timeout;
    logic [CW-1:0] m_cycles;
    logic [DW-1:0] m_rdata;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic [DW-1:0] m_mem [256];

    always @(negedge clk) begin
        logic halt, e_core_en, gnt_now;
        if (!rst_n) begin
            m_run_age = 0; m_host_age = 0; m_done = 1'b0; m_timeout = 1'b0;
            m_cycles = '0; m_rdata = '0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        end
        halt      = (prog_ctr_out == D'(HALT_ADDR));
        e_core_en = (m_run_age >= 2) && !halt;
        check("pc_load",     pc_load,     m_run_age == 1);
        check("pc_load_val", pc_load_val, 0);
        check("core_en",     core_en,     e_core_en);
        check("mem_we",      mem_we,      (e_core_en && core_we) || (m_host_age == 1 && h_we));
        check("mem_addr",    mem_addr,    (m_host_age == 1) ? h_addr : core_addr);
        check("mem_wdata",   mem_wdata,   (m_host_age == 1) ? h_wdata : core_wdata);
        check("host_gnt",    host_gnt,    m_host_age == 2);
        check("host_rdata",  host_rdata,  m_rdata);
        check("done",        done,        m_done);
        check("timeout",     timeout,     m_timeout);
        check("run_cycles",  run_cycles,  m_cycles);
        if (rst_n) begin
            if (m_run_age == 1) begin
                m_run_age = 2;
            end else if (m_run_age >= 2) begin
                if (halt) begin
                    m_run_age = 0; m_done = 1'b1;
                end else begin
                    if (core_we) m_mem[core_addr] = core_wdata;
                    if (m_cycles != 16'hFFFF) m_cycles = m_cycles + 1'b1;
                    if (WD && m_cycles == MAX_CYC) begin
                        m_run_age = 0; m_done = 1'b1; m_timeout = 1'b1;
                    end
                end
            end else if (m_host_age == 1) begin
                m_rdata = m_mem[h_addr];
                if (h_we) m_mem[h_addr] = h_wdata;
                m_host_age = 2;
            end else begin
                gnt_now    = (m_host_age == 2);
                m_host_age = 0;
                if (start) begin
                    m_run_age = 1; m_done = 1'b0; m_timeout = 1'b0; m_cycles = '0;
                end else if (host_req && !gnt_now) begin
                    m_host_age = 1; h_we = host_we; h_addr = host_addr; h_wdata = host_wdata;
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, done, 1);
    endtask

    task automatic wait_gnt(input int budget, output int lat);
        lat = 0;
        @(negedge clk);
        while (host_gnt !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check("gnt_seen", host_gnt, 1);
    endtask

    task automatic host_access(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                               output logic [7:0] rd);
        int lat;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
        wait_gnt(10, lat);
        check("host_latency", lat, 2);
        rd = host_rdata;
        drive_edge();
        host_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] rd;
        int lat;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'h00;
            m_mem[i]   = 8'h00;
        end
        rst_n = 1'b0; start = 1'b0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_core_en", core_en, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_pc_load_val", pc_load_val, 0);
        drive_edge();
        rst_n = 1'b1;

        // Host write then read in IDLE.
        drive_edge();
        host_access(1'b1, 8'h10, 8'hA5, rd);
        host_access(1'b0, 8'h10, 8'h00, rd);
        check("host_rd_10", rd, 8'hA5);

        // Start and host request together: run first, request served after DONE.
        start = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C;
        @(negedge clk);
        check("both_no_gnt", host_gnt, 0);
        drive_edge();
        start = 1'b0;
        @(negedge clk);
        check("load_pulse", pc_load, 1);
        check("load_no_core_en", core_en, 0);
        @(negedge clk);
        check("first_core_en", core_en, 1);
        check("first_pc", prog_ctr_out, 0);
        wait_gnt(400, lat);
        check("gnt_after_done", done, 1);
        check("run1_cycles", run_cycles, 128);
        check("run1_timeout", timeout, 0);
        drive_edge();
        host_req = 1'b0;
        host_access(1'b0, 8'h20, 8'h00, rd);
        check("host_rd_20", rd, 8'h3C);
        check("done_kept_host", done, 1);

        // Start held high through a run: no restart in RUN, restart after DONE.
        start = 1'b1;
        @(negedge clk);
        check("done_until_load", done, 1);
        @(negedge clk);
        check("start_clears_done", done, 0);
        check("run2_load", pc_load, 1);
        wait_done(300, "run2_done");
        check("run2_cycles", run_cycles, 128);
        @(negedge clk);
        check("held_start_restart", pc_load, 1);
        check("restart_done_low", done, 0);
        drive_edge();
        start = 1'b0;
        wait_done(300, "run3_done");

        // Reset in the middle of a run.
        drive_edge();
        start = 1'b1;
        drive_edge();
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_run_core_en", core_en, 1);
        drive_edge();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_core_en", core_en, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_cycles", run_cycles, 0);
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_core_en", core_en, 0);
        check("post_rst_pc_load", pc_load, 0);
        check("post_rst_cycles", run_cycles, 0);

`ifdef RUN_WATCHDOG_EN
        // Watchdog: PC loops below the halt address.
        wrap_en = 1'b1; pc_wrap = 12'd10;
        drive_edge();
        start = 1'b1;
        drive_edge();
        start = 1'b0;
        @(negedge clk);
        wait_done(100, "wd_done");
        check("wd_timeout", timeout, 1);
        check("wd_cycles", run_cycles, 20);
        wrap_en = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
